// File: rtl/load_unit_pkg.sv
// Shared types for the load unit: load-op encodings, FSM states and the
// alignment/legality rule used when a load is accepted.
package load_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LB  = 3'b001,
        OP_LBU = 3'b010,
        OP_LH  = 3'b011,
        OP_LHU = 3'b100
    } load_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // High when the op is unknown or the address is not naturally aligned for it.
    function automatic logic addr_error(input logic [2:0] op, input logic [1:0] addr_lo);
        logic err;
        case (op)
            OP_LW:         err = (addr_lo != 2'b00);
            OP_LB, OP_LBU: err = 1'b0;
            OP_LH, OP_LHU: err = addr_lo[0];
            default:       err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Lane selection and sign/zero extension of a raw memory word for one load op.
module load_extract
    import load_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/half lane, then extend according to the op.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = 32'h0000_0000;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (op)
            OP_LW:   result = rdata;
            OP_LB:   result = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  result = {24'h00_0000, byte_s};
            OP_LH:   result = {{16{half_s[15]}}, half_s};
            OP_LHU:  result = {16'h0000, half_s};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Memory-stage load unit: issues one word read, waits for the response with a
// bounded timeout, and returns the extended result with a one-cycle done pulse.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data_out,
    output logic        done,
    output logic        busy,
    output logic        adel,
    output logic        timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic              adel_q, adel_d;
    logic              timeout_q, timeout_d;
    logic              mem_req_q, mem_req_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [31:0]       ext_s;

    load_extract u_extract (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .rdata   (mem_rdata),
        .result  (ext_s)
    );

    // Next-state and next-output logic; cnt_q counts REQ+WAIT cycles, 1 on the first.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        adel_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    addr_d = addr;
                    if (addr_error(op, addr[1:0])) begin
                        state_d = ST_DONE;
                        adel_d  = 1'b1;
                        data_d  = 32'h0000_0000;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt && mem_rvalid) begin
                    state_d = ST_DONE;
                    data_d  = ext_s;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    data_d    = 32'h0000_0000;
                end else if (mem_gnt) begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT: begin
                // A response on the final allowed cycle still completes normally.
                if (mem_rvalid) begin
                    state_d = ST_DONE;
                    data_d  = ext_s;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    data_d    = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        mem_req_d = (state_d == ST_REQ);
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= 3'b000;
            addr_q    <= 32'h0000_0000;
            cnt_q     <= CNT_ZERO;
            data_q    <= 32'h0000_0000;
            adel_q    <= 1'b0;
            timeout_q <= 1'b0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            adel_q    <= adel_d;
            timeout_q <= timeout_d;
            mem_req_q <= mem_req_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign data_out = data_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign adel     = adel_q;
    assign timeout  = timeout_q;

endmodule
